// File: rtl/sobel_pkg.sv
// Shared types and default image geometry for the Sobel stream address generator.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_IMG_W  = 5;
  localparam int unsigned DEF_IMG_H  = 5;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_PPC    = 1;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_raster_counter.sv
// Raster column/row counter stepping PPC pixels per beat, with frame position flags.
module sobel_raster_counter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PPC   = DEF_PPC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      step_i,
  output logic [cnt_w(IMG_H)-1:0]   row_o,
  output logic [cnt_w(IMG_W)-1:0]   col_o,
  output logic                      sof_o,
  output logic                      eol_o,
  output logic                      eof_o
);

  localparam int unsigned ROW_W = cnt_w(IMG_H);
  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - PPC);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(PPC);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign row_o = row_q;
  assign col_o = col_q;
  assign sof_o = (row_q == '0) && (col_q == '0);
  assign eol_o = (col_q == COL_LAST);
  assign eof_o = eol_o && (row_q == ROW_LAST);

  // Next position: clear wins; a step past the last beat of the frame wraps to the origin.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (eol_o) begin
        col_d = '0;
        row_d = eof_o ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_STEP;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/sobel_stream_addr_gen.sv
// Frame-level address generator: control FSM, latched frame setup and incrementing pixel address.
module sobel_stream_addr_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PPC    = DEF_PPC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         pixel_addr,
  output logic [cnt_w(IMG_H)-1:0]   row,
  output logic [cnt_w(IMG_W)-1:0]   col,
  output logic                      sof,
  output logic                      eol,
  output logic                      eof,
  output logic                      busy,
  output logic                      frame_done
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(PPC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              cont_q, cont_d;
  logic              done_q, done_d;
  logic              valid_q, busy_q;
  logic              cnt_clear, cnt_step;

  sobel_raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PPC   (PPC)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .step_i  (cnt_step),
    .row_o   (row),
    .col_o   (col),
    .sof_o   (sof),
    .eol_o   (eol),
    .eof_o   (eof)
  );

  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign pixel_addr = addr_q;
  assign frame_done = done_q;

  // Next-state, setup latch and address update; abort overrides start and transfer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    cont_d    = cont_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_RUN;
            base_d    = base_addr;
            cont_d    = continuous;
            addr_d    = base_addr;
            cnt_clear = 1'b1;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            // The counter wraps itself to the origin on the eof step, so only the address reloads.
            cnt_step = 1'b1;
            addr_d   = addr_q + ADDR_STEP;
            if (eof) begin
              done_d = 1'b1;
              if (cont_q) addr_d = base_q;
              else        state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; valid/busy registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
      valid_q <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sobel_stream_addr_gen.sv
// Directed bench for sobel_stream_addr_gen: 5x5/PPC1, 4x2/PPC2 and 2x2 continuous instances.
module tb_sobel_stream_addr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 5x5, PPC=1
  logic       start_a, abort_a, cont_a, ready_a;
  logic [7:0] base_a;
  logic       valid_a, sof_a, eol_a, eof_a, busy_a, done_a;
  logic [7:0] addr_a;
  logic [2:0] row_a, col_a;

  // Instance B: 4x2, PPC=2
  logic       start_b, abort_b, cont_b, ready_b;
  logic [7:0] base_b;
  logic       valid_b, sof_b, eol_b, eof_b, busy_b, done_b;
  logic [7:0] addr_b;
  logic [0:0] row_b;
  logic [1:0] col_b;

  // Instance C: 2x2, PPC=1, continuous
  logic       start_c, abort_c, cont_c, ready_c;
  logic [7:0] base_c;
  logic       valid_c, sof_c, eol_c, eof_c, busy_c, done_c;
  logic [7:0] addr_c;
  logic [0:0] row_c, col_c;

  sobel_stream_addr_gen #(.IMG_W(5), .IMG_H(5), .ADDR_W(8), .PPC(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .continuous(cont_a),
    .base_addr(base_a), .out_valid(valid_a), .out_ready(ready_a), .pixel_addr(addr_a),
    .row(row_a), .col(col_a), .sof(sof_a), .eol(eol_a), .eof(eof_a),
    .busy(busy_a), .frame_done(done_a)
  );

  sobel_stream_addr_gen #(.IMG_W(4), .IMG_H(2), .ADDR_W(8), .PPC(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .continuous(cont_b),
    .base_addr(base_b), .out_valid(valid_b), .out_ready(ready_b), .pixel_addr(addr_b),
    .row(row_b), .col(col_b), .sof(sof_b), .eol(eol_b), .eof(eof_b),
    .busy(busy_b), .frame_done(done_b)
  );

  sobel_stream_addr_gen #(.IMG_W(2), .IMG_H(2), .ADDR_W(8), .PPC(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .continuous(cont_c),
    .base_addr(base_c), .out_valid(valid_c), .out_ready(ready_c), .pixel_addr(addr_c),
    .row(row_c), .col(col_c), .sof(sof_c), .eol(eol_c), .eof(eof_c),
    .busy(busy_c), .frame_done(done_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge, first beat visible one negedge later.
  task automatic pulse_start_a(input logic [7:0] base, input logic cont);
    start_a = 1'b1;
    base_a  = base;
    cont_a  = cont;
    @(negedge clk);
    start_a = 1'b0;
    base_a  = 8'h00;
    cont_a  = 1'b0;
  endtask

  // Walks a 5x5 frame on instance A; abort_at >= 0 aborts while that beat is presented.
  task automatic frame_a(input logic [7:0] base, input bit toggle, input int abort_at,
                         output logic [7:0] last_addr);
    int  idx  = 0;
    int  cyc  = 0;
    bit  fin  = 0;
    bit  rdy;
    logic [7:0] ea;
    last_addr = 8'h00;
    while (!fin) begin
      if (cyc >= 400) begin
        check("a_timeout", 32'd0, 32'd1);
        fin = 1;
      end else begin
        rdy     = toggle ? (cyc % 2 == 0) : 1'b1;
        ready_a = rdy;
        if (idx == abort_at) abort_a = 1'b1;
        ea = base + 8'(idx);
        check("a_valid", valid_a, 1);
        check("a_addr",  addr_a, ea);
        check("a_row",   row_a, idx / 5);
        check("a_col",   col_a, idx % 5);
        check("a_sof",   sof_a, idx == 0);
        check("a_eol",   eol_a, (idx % 5) == 4);
        check("a_eof",   eof_a, idx == 24);
        check("a_done_mid", done_a, 0);
        if (abort_a) fin = 1;
        else if (rdy) begin
          last_addr = ea;
          idx++;
          if (idx == 25) fin = 1;
        end
        @(negedge clk);
        abort_a = 1'b0;
        ready_a = 1'b1;
        cyc++;
      end
    end
  endtask

  task automatic post_frame_a();
    check("a_done_pulse", done_a, 1);
    check("a_valid_done", valid_a, 0);
    check("a_busy_done",  busy_a, 1);
    @(negedge clk);
    check("a_done_clear", done_a, 0);
  endtask

  logic [7:0] exp_b_addr [4];
  logic [7:0] exp_c_addr [4];
  logic [7:0] last;

  initial begin
    exp_b_addr = '{8'h00, 8'h02, 8'h04, 8'h06};
    exp_c_addr = '{8'h40, 8'h41, 8'h42, 8'h43};
    {start_a, abort_a, cont_a, ready_a} = 4'b0001;
    {start_b, abort_b, cont_b, ready_b} = 4'b0001;
    {start_c, abort_c, cont_c, ready_c} = 4'b0001;
    base_a = 8'h00; base_b = 8'h00; base_c = 8'h00;
    rst = 1'b1;

    // Reset state
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_addr",  addr_a, 0);
    check("rst_row",   row_a, 0);
    check("rst_col",   col_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_valid_c", valid_c, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Frame at 0x10, start on the first edge with rst low, ready held high
    pulse_start_a(8'h10, 1'b0);
    frame_a(8'h10, 1'b0, -1, last);
    check("a_last_0x28", last, 8'h28);
    post_frame_a();

    // Restart from DONE with out_ready toggling
    pulse_start_a(8'h10, 1'b0);
    frame_a(8'h10, 1'b1, -1, last);
    check("a_last_toggle", last, 8'h28);
    post_frame_a();

    // Abort at beat 7, then restart at 0x00
    pulse_start_a(8'h20, 1'b0);
    frame_a(8'h20, 1'b0, 7, last);
    check("abort_valid", valid_a, 0);
    check("abort_busy",  busy_a, 0);
    check("abort_done",  done_a, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done_a, 0);
    end
    pulse_start_a(8'h00, 1'b0);
    frame_a(8'h00, 1'b0, -1, last);
    check("a_last_0x18", last, 8'h18);
    post_frame_a();

    // Abort beats a simultaneous start from DONE
    start_a = 1'b1; abort_a = 1'b1; base_a = 8'h55;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0; base_a = 8'h00;
    check("abort_vs_start_busy",  busy_a, 0);
    check("abort_vs_start_valid", valid_a, 0);

    // Address wrap modulo 256
    pulse_start_a(8'hF0, 1'b0);
    frame_a(8'hF0, 1'b0, -1, last);
    check("a_last_wrap", last, 8'h08);
    post_frame_a();

    // Asynchronous reset mid-frame
    pulse_start_a(8'h30, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_addr", addr_a, 8'h32);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", valid_a, 0);
    check("arst_busy",  busy_a, 0);
    check("arst_addr",  addr_a, 0);
    check("arst_col",   col_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("arst_no_done",  done_a, 0);
      check("arst_no_valid", valid_a, 0);
    end

    // PPC=2, 4x2 frame at base 0
    start_b = 1'b1; base_b = 8'h00;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_valid", valid_b, 1);
      check("b_addr",  addr_b, exp_b_addr[i]);
      check("b_row",   row_b, i / 2);
      check("b_col",   col_b, (i % 2) * 2);
      check("b_sof",   sof_b, i == 0);
      check("b_eol",   eol_b, (i % 2) == 1);
      check("b_eof",   eof_b, i == 3);
      @(negedge clk);
    end
    check("b_done",  done_b, 1);
    check("b_valid_end", valid_b, 0);

    // Continuous 2x2 frames at 0x40, no bubble between frames
    start_c = 1'b1; cont_c = 1'b1; base_c = 8'h40;
    @(negedge clk);
    start_c = 1'b0; cont_c = 1'b0; base_c = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check("c_valid", valid_c, 1);
      check("c_addr",  addr_c, exp_c_addr[i % 4]);
      check("c_sof",   sof_c, (i % 4) == 0);
      check("c_eof",   eof_c, (i % 4) == 3);
      check("c_done",  done_c, (i == 4) || (i == 8));
      @(negedge clk);
    end
    abort_c = 1'b1;
    @(negedge clk);
    abort_c = 1'b0;
    check("c_abort_valid", valid_c, 0);
    check("c_abort_busy",  busy_c, 0);
    check("c_abort_done",  done_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobel_stream_addr_gen.md
SOBEL_STREAM_ADDR_GEN -- requirements
Module: sobel_stream_addr_gen

Interface
REQ-001 Parameter IMG_W, 5, image width in pixels; SHALL be a multiple of PPC.
REQ-002 Parameter IMG_H, 5, image height in rows.
REQ-003 Parameter ADDR_W, 8, address width.
REQ-004 Parameter PPC, 1, pixels per beat (1, 2 or 4).
REQ-005 Ports SHALL be:
 clk  in  1  sole clock, rising edge.
 rst  in  1  asynchronous, active-high reset.
 start  in  1  frame start request, sampled in IDLE/DONE.
 abort  in  1  synchronous frame abort.
 continuous  in  1  auto-restart at frame end, sampled at start.
 base_addr  in  ADDR_W  frame base address, latched on accepted start.
 out_valid  out  1  beat valid.
 out_ready  in  1  downstream accept.
 pixel_addr  out  ADDR_W  address of first pixel in beat.
 row  out  max(1,$clog2(IMG_H))  current row.
 col  out  max(1,$clog2(IMG_W))  first column of beat.
 sof  out  1  first beat of frame.
 eol  out  1  last beat of row.
 eof  out  1  last beat of frame.
 busy  out  1  state != IDLE.
 frame_done  out  1  one-cycle pulse after last beat.

Function
REQ-006 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-007 IDLE/DONE + start=1 -> RUN next cycle; base_addr and continuous latched; row=0, col=0, pixel_addr=base_addr.
REQ-008 out_valid SHALL be 1 exactly in RUN; first beat one cycle after accepted start.
REQ-009 Beat transfers when out_valid && out_ready; pixel_addr, row, col, sof, eol, eof SHALL hold stable while out_valid && !out_ready.
REQ-010 On transfer: col += PPC, pixel_addr += PPC; at col==IMG_W-PPC: col=0, row+1; addresses contiguous row to row (pixel_addr = base + row*IMG_W + col).
REQ-011 Address increment only, no multiplier; pixel_addr wraps modulo 2^ADDR_W.
REQ-012 sof = (row==0 && col==0); eol = (col==IMG_W-PPC); eof = eol && row==IMG_H-1; all combinationally derived from registered counters.
REQ-013 Transfer of eof beat with latched continuous=0 -> DONE, out_valid=0, frame_done=1 for exactly one cycle.
REQ-014 Transfer of eof beat with continuous=1 -> stay RUN, row=col=0, pixel_addr=latched base, frame_done pulses, no bubble.
REQ-015 start in RUN SHALL be ignored; DONE + start behaves as IDLE + start.
REQ-016 abort=1 (any state) -> IDLE next cycle, out_valid=0, no frame_done; abort wins over simultaneous start and transfer.
REQ-017 IMG_H=1 or IMG_W=PPC SHALL be legal; single-beat frame asserts sof, eol, eof together.

Reset
REQ-018 rst asserted -> immediately: IDLE, out_valid=0, pixel_addr=0, row=0, col=0, frame_done=0, busy=0, latched base/continuous=0.
REQ-019 rst mid-frame SHALL discard the frame; no frame_done after deassertion.
REQ-020 First start accepted on the first rising edge with rst low.

Structure
REQ-021 Package sobel_pkg SHALL hold the FSM state enum and shared image-size constants.
REQ-022 One sub-module sobel_raster_counter (col/row counter, step PPC, eol/eof flags); FSM and address register in top.
REQ-023 Synthesisable, no latches, all outputs registered except the sof/eol/eof decode.

Verification
REQ-024 W=5,H=5,PPC=1, base 0x10, ready=1 -> 25 beats 0x10..0x28, eol at 0x14,0x19,..., eof at 0x28, frame_done one cycle later.
REQ-025 Same, out_ready toggled 1/0 -> identical address sequence, outputs stable during stalls, 25 transfers.
REQ-026 W=4,H=2,PPC=2, base 0 -> addrs 0,2,4,6; eol at 2 and 6; eof at 6.
REQ-027 continuous=1, W=2,H=2, base 0x40 -> 0x40,0x41,0x42,0x43,0x40,...; frame_done every 4th transfer, no bubble.
REQ-028 abort at beat 7, then start base 0x00 -> restart at 0x00 with sof; no frame_done for aborted frame.
REQ-029 ADDR_W=8, base 0xF0, W=5,H=5 -> last address 0x08 (wrap); async rst mid-frame -> out_valid=0 without clock edge.
